// File: rtl/qoa_pkg.sv
// Shared definitions for the QOA SPI slave front-end: SPI mode encodings and
// the transfer FSM state type.
package qoa_pkg;

   localparam logic [1:0] SPI_MODE0 = 2'd0;
   localparam logic [1:0] SPI_MODE1 = 2'd1;
   localparam logic [1:0] SPI_MODE2 = 2'd2;
   localparam logic [1:0] SPI_MODE3 = 2'd3;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } spi_state_e;

   // Mode number bit 1 is the clock polarity, bit 0 the clock phase.
   function automatic logic mode_cpol(input logic [1:0] mode);
      return mode[1];
   endfunction

   function automatic logic mode_cpha(input logic [1:0] mode);
      return mode[0];
   endfunction

endpackage

// File: rtl/qoa_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers and a registered head word.
// A push while full is dropped unless a pop happens in the same cycle.
module qoa_sync_fifo
   import qoa_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head,
   output logic             drop
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] head_q, head_d;
   logic [AW:0]      wr_q, wr_d, rd_q, rd_d, rd_next_s;
   logic             push_en_s, pop_en_s;

   assign empty     = (wr_q == rd_q);
   assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign pop_en_s  = pop & ~empty;
   assign push_en_s = push & (~full | pop_en_s);
   assign drop      = push & full & ~pop_en_s;
   assign rd_next_s = rd_q + PTR_ONE;
   assign head      = head_q;

   always_comb begin
      wr_d   = push_en_s ? (wr_q + PTR_ONE) : wr_q;
      rd_d   = pop_en_s ? rd_next_s : rd_q;
      head_d = head_q;
      // The head register looks ahead so it always shows the entry at rd_d.
      if (pop_en_s) begin
         if (push_en_s && (rd_next_s == wr_q)) begin
            head_d = push_data;
         end else begin
            head_d = mem_q[rd_next_s[AW-1:0]];
         end
      end else if (push_en_s && empty) begin
         head_d = push_data;
      end else begin
         head_d = head_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q   <= '0;
         rd_q   <= '0;
         head_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         head_q <= head_d;
         if (push_en_s) begin
            mem_q[wr_q[AW-1:0]] <= push_data;
         end
      end
   end

endmodule

// File: rtl/qoa_spi_slave.sv
// SPI slave front-end for the QOA decoder, oversampled in the sys_clk domain.
// RX words go to a FIFO; TX words come from a one-entry holding register.
module qoa_spi_slave
   import qoa_pkg::*;
#(
   parameter int RX_W        = 8,
   parameter int TX_W        = 16,
   parameter bit CPOL        = 1'b0,
   parameter bit CPHA        = 1'b0,
   parameter int SYNC_STAGES = 2,
   parameter int RX_DEPTH    = 4
) (
   input  logic            sys_clk,
   input  logic            sys_rst,
   input  logic            spi_sclk,
   input  logic            spi_cs_n,
   input  logic            spi_mosi,
   output logic            spi_miso,
   output logic            spi_miso_oe,
   output logic [RX_W-1:0] rx_data,
   output logic            rx_valid,
   input  logic            rx_ready,
   output logic            rx_overflow,
   input  logic [TX_W-1:0] tx_data,
   input  logic            tx_valid,
   output logic            tx_ready,
   output logic            tx_underrun,
   output logic            busy
);

   localparam int RXC_W = $clog2(RX_W);
   localparam int TXC_W = $clog2(TX_W);
   localparam logic [RXC_W-1:0] RX_LAST = RXC_W'(RX_W - 1);
   localparam logic [RXC_W-1:0] RX_ONE  = RXC_W'(1);
   localparam logic [TXC_W-1:0] TX_LAST = TXC_W'(TX_W - 1);
   localparam logic [TXC_W-1:0] TX_ONE  = TXC_W'(1);
   localparam logic FIRST_INIT = CPHA;

   logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
   logic sclk_prev_q, cs_prev_q;
   logic sclk_s, cs_s, mosi_s;
   logic lead_s, trail_s, sample_s, shift_s, cs_fall_s, cs_rise_s;

   spi_state_e state_q, state_d;
   logic [RX_W-1:0]  rx_shift_q, rx_shift_d, word_q, word_d;
   logic [RXC_W-1:0] rx_cnt_q, rx_cnt_d;
   logic [TX_W-1:0]  tx_shift_q, tx_shift_d, hold_q, hold_d;
   logic [TXC_W-1:0] tx_cnt_q, tx_cnt_d;
   logic tx_first_q, tx_first_d, word_push_q, word_push_d;
   logic hold_valid_q, hold_valid_d, frame_load_s;
   logic miso_q, miso_d, underrun_q, underrun_d, overflow_q;
   logic fifo_full_s, fifo_empty_s, fifo_drop_s;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         sclk_sync_q <= {SYNC_STAGES{CPOL}};
         cs_sync_q   <= '1;
         mosi_sync_q <= '0;
         sclk_prev_q <= CPOL;
         cs_prev_q   <= 1'b1;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
         sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
         cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
      end
   end

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign lead_s    = (sclk_s != sclk_prev_q) && (sclk_s != CPOL);
   assign trail_s   = (sclk_s != sclk_prev_q) && (sclk_s == CPOL);
   assign cs_fall_s = ~cs_s & cs_prev_q;
   assign cs_rise_s = cs_s & ~cs_prev_q;

   generate
      if (CPHA == 1'b0) begin : g_cpha0
         assign sample_s = lead_s;
         assign shift_s  = trail_s;
      end else begin : g_cpha1
         assign sample_s = trail_s;
         assign shift_s  = lead_s;
      end
   endgenerate

   always_comb begin
      state_d      = state_q;
      rx_shift_d   = rx_shift_q;
      rx_cnt_d     = rx_cnt_q;
      tx_shift_d   = tx_shift_q;
      tx_cnt_d     = tx_cnt_q;
      tx_first_d   = tx_first_q;
      word_d       = word_q;
      word_push_d  = 1'b0;
      frame_load_s = 1'b0;
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      underrun_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cs_fall_s) begin
               state_d      = ST_ACTIVE;
               rx_shift_d   = '0;
               rx_cnt_d     = '0;
               tx_cnt_d     = '0;
               tx_first_d   = FIRST_INIT;
               frame_load_s = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACTIVE: begin
            if (cs_rise_s) begin
               // Abandon any partial word in both directions.
               state_d    = ST_IDLE;
               rx_shift_d = '0;
               rx_cnt_d   = '0;
               tx_shift_d = '0;
               tx_cnt_d   = '0;
               tx_first_d = 1'b0;
            end else begin
               if (sample_s) begin
                  rx_shift_d = {rx_shift_q[RX_W-2:0], mosi_s};
                  if (rx_cnt_q == RX_LAST) begin
                     rx_cnt_d    = '0;
                     word_d      = rx_shift_d;
                     word_push_d = 1'b1;
                  end else begin
                     rx_cnt_d = rx_cnt_q + RX_ONE;
                  end
               end else begin
                  rx_cnt_d = rx_cnt_q;
               end
               if (shift_s) begin
                  if (tx_first_q) begin
                     tx_first_d = 1'b0;
                  end else if (tx_cnt_q == TX_LAST) begin
                     tx_cnt_d     = '0;
                     frame_load_s = 1'b1;
                  end else begin
                     tx_shift_d = tx_shift_q << 1;
                     tx_cnt_d   = tx_cnt_q + TX_ONE;
                  end
               end else begin
                  tx_cnt_d = tx_cnt_q;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Frame load reads the holding register as it was before any load this cycle.
      if (frame_load_s) begin
         if (hold_valid_q) begin
            tx_shift_d   = hold_q;
            hold_valid_d = 1'b0;
         end else begin
            tx_shift_d = '0;
            underrun_d = 1'b1;
         end
      end else begin
         underrun_d = 1'b0;
      end
      if (tx_valid && !hold_valid_q) begin
         hold_d       = tx_data;
         hold_valid_d = 1'b1;
      end else begin
         hold_d = hold_q;
      end

      miso_d = (state_d == ST_ACTIVE) ? tx_shift_d[TX_W-1] : 1'b0;
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q      <= ST_IDLE;
         rx_shift_q   <= '0;
         rx_cnt_q     <= '0;
         tx_shift_q   <= '0;
         tx_cnt_q     <= '0;
         tx_first_q   <= 1'b0;
         word_q       <= '0;
         word_push_q  <= 1'b0;
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
         miso_q       <= 1'b0;
         underrun_q   <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         rx_shift_q   <= rx_shift_d;
         rx_cnt_q     <= rx_cnt_d;
         tx_shift_q   <= tx_shift_d;
         tx_cnt_q     <= tx_cnt_d;
         tx_first_q   <= tx_first_d;
         word_q       <= word_d;
         word_push_q  <= word_push_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         miso_q       <= miso_d;
         underrun_q   <= underrun_d;
         overflow_q   <= fifo_drop_s & ~fifo_full_s ? 1'b0 : fifo_drop_s;
      end
   end

   qoa_sync_fifo #(
      .WIDTH (RX_W),
      .DEPTH (RX_DEPTH)
   ) u_rx_fifo (
      .clk       (sys_clk),
      .rst       (sys_rst),
      .push      (word_push_q),
      .push_data (word_q),
      .pop       (rx_ready),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s),
      .head      (rx_data),
      .drop      (fifo_drop_s)
   );

   assign rx_valid    = ~fifo_empty_s;
   assign rx_overflow = overflow_q;
   assign tx_ready    = ~hold_valid_q;
   assign tx_underrun = underrun_q;
   assign spi_miso    = miso_q;
   assign spi_miso_oe = (state_q == ST_ACTIVE);
   assign busy        = (state_q == ST_ACTIVE);

endmodule
